// File: rtl/fdiv_arb_pkg.sv
// fdiv_arb_pkg: shared types and sizing constants for the fdiv_arbiter block.
//   float32_t        - IEEE-754 binary32 viewed as sign / exponent / mantissa
//   fdiv_arb_state_t - arbiter FSM states (IDLE, CALC, RESP)
//   NREQ_MAX         - largest supported requester count
//   PTR_W            - width of the round-robin pointer / grant index
//   CNT_W            - width of the multicycle countdown register
package fdiv_arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = $clog2(NREQ_MAX);
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } fdiv_arb_state_t;

endpackage

// File: rtl/fdiv.sv
// fdiv: combinational single-precision divider shared by fdiv_arbiter.
// Ports:
//   x1 [31:0] - dividend, binary32
//   x2 [31:0] - divisor, binary32
//   y  [31:0] - quotient, binary32
// Quotient mantissa is truncated. Zero and denormal dividends flush to a
// signed zero; a zero/denormal divisor yields signed infinity (NaN for 0/0);
// any Inf/NaN operand yields the default quiet NaN.
module fdiv
  import fdiv_arb_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);

  float32_t           a;
  float32_t           b;
  logic               sgn;
  logic [47:0]        num;
  logic [47:0]        den;
  logic [24:0]        q;
  logic signed [9:0]  e;

  // Both mantissas carry the hidden bit, so the quotient of (m1 << 24) / m2
  // lies in (2^23, 2^25); bit 24 tells whether one normalising shift is needed.
  always_comb begin
    a   = x1;
    b   = x2;
    sgn = a.sign ^ b.sign;
    num = {1'b1, a.man, 24'b0};
    den = {24'b0, 1'b1, b.man};
    q   = 25'(num / den);
    e   = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'sd126
          + $signed({9'b0, q[24]});
    y   = '0;
    if (a.exp == 8'hFF || b.exp == 8'hFF) begin
      y = 32'h7FC0_0000;
    end else if (b.exp == 8'd0) begin
      y = (a.exp == 8'd0) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'b0};
    end else if (a.exp == 8'd0) begin
      y = {sgn, 31'b0};
    end else if (e >= 10'sd255) begin
      y = {sgn, 8'hFF, 23'b0};
    end else if (e <= 10'sd0) begin
      y = {sgn, 31'b0};
    end else begin
      y = {sgn, e[7:0], (q[24] ? q[23:1] : q[22:0])};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick among N requests.
// Ports:
//   req     [N]     - request vector
//   ptr     [PTR_W] - index of the last winner; search starts at ptr+1
//   gnt     [N]     - one-hot grant (all zero when no request)
//   gnt_idx [PTR_W] - binary index of the granted request
module rr_arbiter
  import fdiv_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W:0] idx;
  logic           found;

  // Walk ptr+1, ptr+2, ... wrapping at N; the first asserted request wins,
  // so the previous winner (offset N) is checked last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(N)) begin
        idx = idx - (PTR_W + 1)'(N);
      end
      if (!found && |(req & (N'(1) << idx))) begin
        found   = 1'b1;
        gnt     = N'(1) << idx;
        gnt_idx = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: shares one combinational fdiv among NREQ requesters with
// round-robin grants and a single operation in flight. The divider is held
// for LATENCY cycles on registered operands (multicycle path).
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req_valid/ready  - per-requester request handshake (ready is one-hot)
//   req_x1, req_x2   - per-requester dividend / divisor (binary32)
//   resp_valid/ready - per-requester response handshake (valid is one-hot)
//   resp_y           - shared quotient register
//   busy             - FSM is not in IDLE
// Build option: define FDIV_ARB_ZERO_BYPASS_EN to answer zero/denormal
// dividends with a signed zero directly from IDLE, skipping CALC.
module fdiv_arbiter
  import fdiv_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][31:0] req_x1,
  input  logic [NREQ-1:0][31:0] req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_y,
  output logic                 busy
);

  fdiv_arb_state_t  state_q, state_d;
  float32_t         x1_q, x1_d;
  float32_t         x2_q, x2_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      resp_y_q, resp_y_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  float32_t         x1_sel;
  float32_t         x2_sel;
  logic [31:0]      fdiv_y;

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  fdiv u_fdiv (
    .x1 (x1_q),
    .x2 (x2_q),
    .y  (fdiv_y)
  );

  // Operand mux steered by the one-hot grant.
  always_comb begin
    x1_sel = '0;
    x2_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        x1_sel = req_x1[i];
        x2_sel = req_x2[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    resp_y_d   = resp_y_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = arb_gnt;
        if (|arb_gnt) begin
          x1_d    = x1_sel;
          x2_d    = x2_sel;
          grant_d = arb_gnt;
          ptr_d   = arb_idx;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = CALC;
`ifdef FDIV_ARB_ZERO_BYPASS_EN
          if (x1_sel.exp == 8'd0) begin
            resp_y_d = {x1_sel.sign ^ x2_sel.sign, 31'b0};
            state_d  = RESP;
          end
`endif
        end
      end
      CALC: begin
        // The divider output is only trusted once cnt has run down.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          resp_y_d = fdiv_y;
          state_d  = RESP;
        end
      end
      RESP: begin
        resp_valid = grant_q;
        if (|(grant_q & resp_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x1_q     <= '0;
      x2_q     <= '0;
      grant_q  <= '0;
      ptr_q    <= PTR_W'(NREQ - 1);
      cnt_q    <= '0;
      resp_y_q <= '0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      resp_y_q <= resp_y_d;
    end
  end

  assign resp_y = resp_y_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb_fdiv_arbiter: directed self-checking bench for fdiv_arbiter
// (NREQ=4, LATENCY=2). Inputs are driven and outputs sampled 1 time unit
// after the falling clock edge.
module tb_fdiv_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 2;
`ifdef FDIV_ARB_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = LATENCY + 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_x1;
  logic [NREQ-1:0][31:0] req_x2;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [31:0]           resp_y;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fdiv_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  // One complete request/response for requester idx with resp_ready high.
  task automatic applyStimulus(input string tag, input int idx, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [31:0] exp_y);
    bit got;
    req_x1[idx] = x1;
    req_x2[idx] = x2;
    req_valid   = NREQ'(1 << idx);
    #1;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      nextCycle();
    end
    checkOutput({tag, "_grant"}, req_ready, 32'(1 << idx));
    nextCycle();
    req_valid = '0;
    #1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (resp_valid != '0) begin
        got = 1'b1;
        break;
      end
      nextCycle();
    end
    checkOutput({tag, "_resp_seen"}, 32'(got), 32'd1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 32'(1 << idx));
    checkOutput({tag, "_resp_y"}, resp_y, exp_y);
    nextCycle();
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int k, r, last, lat;
    bit got;

    rst        = 1'b1;
    req_valid  = '0;
    req_x1     = '0;
    req_x2     = '0;
    resp_ready = '1;

    // Reset state and single op, checked cycle by cycle: 6.0 / 2.0 = 3.0
    resetDut();
    checkOutput("rst_req_ready", req_ready, 32'h0);
    checkOutput("rst_resp_valid", resp_valid, 32'h0);
    checkOutput("rst_resp_y", resp_y, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);
    req_x1[1] = 32'h40C0_0000;
    req_x2[1] = 32'h4000_0000;
    req_valid = 4'b0010;
    #1;
    checkOutput("single_c0_req_ready", req_ready, 32'h2);
    checkOutput("single_c0_busy", busy, 32'h0);
    nextCycle();
    req_valid = '0;
    #1;
    checkOutput("single_c1_busy", busy, 32'h1);
    checkOutput("single_c1_resp_valid", resp_valid, 32'h0);
    nextCycle();
    checkOutput("single_c2_resp_valid", resp_valid, 32'h0);
    nextCycle();
    checkOutput("single_c3_resp_valid", resp_valid, 32'h2);
    checkOutput("single_c3_resp_y", resp_y, 32'h4040_0000);
    nextCycle();
    checkOutput("single_c4_busy", busy, 32'h0);

    // Round robin: all requesters pending, 1.0 / 4.0 = 0.25
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      req_x1[i] = 32'h3F80_0000;
      req_x2[i] = 32'h4080_0000;
    end
    req_valid = '1;
    #1;
    k    = 0;
    r    = 0;
    last = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (req_ready != '0 && k < 5) begin
        checkOutput("rr_grant", req_ready, 32'(1 << exp_order[k]));
        if (k > 0) checkOutput("rr_spacing", 32'(cyc - last), 32'(LATENCY + 2));
        last = cyc;
        k++;
      end
      if (resp_valid != '0 && r < 5) begin
        checkOutput("rr_resp_owner", resp_valid, 32'(1 << exp_order[r]));
        checkOutput("rr_resp_y", resp_y, 32'h3E80_0000);
        r++;
      end
      if (r == 5) break;
      nextCycle();
      if (k == 5) begin
        req_valid = '0;
        #1;
      end
    end
    checkOutput("rr_responses", 32'(r), 32'd5);
    nextCycle();

    // Backpressure on requester 2 while requester 0 waits; other
    // requesters' resp_ready are high and must be ignored.
    resetDut();
    resp_ready = 4'b1011;
    req_x1[2]  = 32'h40C0_0000;
    req_x2[2]  = 32'h4000_0000;
    req_valid  = 4'b0100;
    #1;
    checkOutput("bp_grant2", req_ready, 32'h4);
    nextCycle();
    req_x1[0] = 32'h3F80_0000;
    req_x2[0] = 32'h4080_0000;
    req_valid = 4'b0001;
    #1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (resp_valid != '0) begin
        got = 1'b1;
        break;
      end
      checkOutput("bp_wait_no_grant", req_ready, 32'h0);
      nextCycle();
    end
    checkOutput("bp_resp_seen", 32'(got), 32'd1);
    for (int n = 0; n < 10; n++) begin
      checkOutput("bp_hold_valid", resp_valid, 32'h4);
      checkOutput("bp_hold_y", resp_y, 32'h4040_0000);
      checkOutput("bp_no_grant", req_ready, 32'h0);
      nextCycle();
    end
    resp_ready = 4'b0100;
    nextCycle();
    checkOutput("bp_grant0_after", req_ready, 32'h1);
    checkOutput("bp_resp_dropped", resp_valid, 32'h0);
    nextCycle();
    req_valid  = '0;
    resp_ready = '1;
    #1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (resp_valid != '0) begin
        got = 1'b1;
        break;
      end
      nextCycle();
    end
    checkOutput("bp_r0_seen", 32'(got), 32'd1);
    checkOutput("bp_r0_valid", resp_valid, 32'h1);
    checkOutput("bp_r0_y", resp_y, 32'h3E80_0000);
    nextCycle();

    // Zero dividend: -0.0 / 2.0 = -0.0
    resetDut();
    req_x1[3] = 32'h8000_0000;
    req_x2[3] = 32'h4000_0000;
    req_valid = 4'b1000;
    #1;
    checkOutput("zero_grant", req_ready, 32'h8);
    nextCycle();
    req_valid = '0;
    #1;
    lat = 1;
    while (resp_valid == '0 && lat < 20) begin
      nextCycle();
      lat++;
    end
    checkOutput("zero_latency", 32'(lat), 32'(ZERO_LAT));
    checkOutput("zero_resp_valid", resp_valid, 32'h8);
    checkOutput("zero_resp_y", resp_y, 32'h8000_0000);
    nextCycle();

    // Directed operand table through the full handshake.
    resetDut();
    applyStimulus("t_7_div_m2", 3, 32'h40E0_0000, 32'hC000_0000, 32'hC060_0000);
    applyStimulus("t_1p5_div_0p75", 2, 32'h3FC0_0000, 32'h3F40_0000, 32'h4000_0000);
    applyStimulus("t_1_div_4", 0, 32'h3F80_0000, 32'h4080_0000, 32'h3E80_0000);
    applyStimulus("t_6_div_2", 1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

    // Reset mid-CALC aborts the op and restores the pointer.
    resetDut();
    req_x1[2] = 32'h40C0_0000;
    req_x2[2] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1;
    checkOutput("abort_grant", req_ready, 32'h4);
    nextCycle();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    checkOutput("abort_busy_calc", busy, 32'h1);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 32'h0);
    checkOutput("abort_resp_valid", resp_valid, 32'h0);
    checkOutput("abort_req_ready", req_ready, 32'h0);
    checkOutput("abort_resp_y", resp_y, 32'h0);
    got = 1'b0;
    for (int n = 0; n < 6; n++) begin
      nextCycle();
      if (resp_valid != '0) got = 1'b1;
    end
    checkOutput("abort_no_resp", 32'(got), 32'd0);
    req_valid = '1;
    #1;
    checkOutput("abort_ptr_restored", req_ready, 32'h1);
    req_valid = '0;
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fdiv_arbiter.md
# fdiv_arbiter

Shares one combinational `fdiv` single-precision divider among `NREQ` requesters, such as FPU issue ports or the memory-side reciprocal helper. Each requester has a valid/ready request channel and a valid/ready response channel. Grants are round-robin, and one division is in flight at a time. The divider is treated as a multicycle path of `LATENCY` cycles, so its combinational depth never sets the core clock.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `LATENCY`, default 2: cycles the registered operands are held on `fdiv` before the result is sampled, ≥1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input [NREQ]: request pending per requester.
- `req_x1` input [NREQ][32]: dividend, IEEE-754 binary32.
- `req_x2` input [NREQ][32]: divisor, IEEE-754 binary32.
- `req_ready` output [NREQ]: one-hot or zero; request accepted this cycle.
- `resp_valid` output [NREQ]: one-hot or zero; result for that requester is on `resp_y`.
- `resp_ready` input [NREQ]: requester accepts its result.
- `resp_y` output 32: quotient, shared by all requesters.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states are IDLE, CALC and RESP. Reset state is IDLE.
- **IDLE:**
  - Round-robin arbiter picks one asserted `req_valid`. `req_ready[g]`=1 combinationally for the winner only.
  - On the accepting edge: register `req_x1[g]` and `req_x2[g]`, store the one-hot grant, update the priority pointer to g, and load `cnt`=LATENCY-1. Next state is CALC.
  - No `req_valid` asserted: stay in IDLE, all `req_ready`=0.
- **CALC:**
  - `fdiv` input is driven by the operand registers only.
  - `cnt`≠0: decrement.
  - `cnt`=0: capture `fdiv` output into the `resp_y` register and go to RESP.
- **RESP:**
  - `resp_valid[g]`=1 and `resp_y` stable until `resp_valid[g]` and `resp_ready[g]` are both 1 at an edge. Next state is IDLE.
  - `resp_ready` of non-granted requesters is ignored.
- **Round-robin rule:**
  - Priority starts at pointer+1 and wraps at NREQ-1 → 0.
  - Reset pointer is NREQ-1, so requester 0 wins first.
  - A requester that was just served is lowest priority for the next grant.
- **Requester obligations:**
  - Hold `req_valid` and operands stable until `req_ready`.
  - `req_valid` must not depend on `req_ready`.
  - At most one outstanding request per requester; this follows from the single in-flight op.
- **Arithmetic:**
  - Results are exactly `fdiv`'s bit output; no rounding or fix-up happens here.
  - Divisor exponent 0 (zero or denormal): result is `fdiv`'s output, passed through unchanged.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_y`=0, `busy`=0, pointer=NREQ-1, `cnt`=0.
- `rst` asserted in any state, including mid-CALC or mid-RESP, aborts the in-flight op. No response is ever issued for it, and IDLE follows the next edge.
- Request handshake in cycle c:
  - `busy`=1 from c+1.
  - CALC occupies cycles c+1..c+LATENCY.
  - `resp_valid` rises in cycle c+LATENCY+1.
- Response handshake in cycle r: IDLE in r+1, and the next acceptance is possible in r+1.
- Minimum spacing between acceptances is LATENCY+2 cycles when `resp_ready` is held high.
- Request acceptance and response handshake never occur in the same cycle.
- `resp_ready` held low: stays in RESP indefinitely, no new grants, pending requests keep waiting.

## Configuration
- `FDIV_ARB_ZERO_BYPASS_EN` defined:
  - An accepted request whose `req_x1[30:23]`=0 skips CALC and goes straight to RESP.
  - `resp_y` = {x1[31]^x2[31], 31'b0}.
  - `resp_valid` rises in c+1.
- Macro undefined:
  - Zero and denormal dividends take the normal CALC path. Latency is uniform at LATENCY+1.
  - The result must still have `resp_y[30:0]`=0.

## Structure
- Package `fdiv_arb_pkg`:
  - `float32_t` (32-bit packed: sign, exp[8], man[23]).
  - State enum `fdiv_arb_state_t` {IDLE, CALC, RESP}.
  - `NREQ_MAX`=8 and the width of `cnt`.
- Sub-module `rr_arbiter`, parameter N:
  - Ports: `req[N]`, `ptr`, `gnt[N]` one-hot, and `gnt_idx`.
  - Purely combinational; the pointer register lives in `fdiv_arbiter`.
- `fdiv` is instantiated once, unmodified.

## Test plan
- **Single op:** requester 1 sends x1=0x40C00000, x2=0x40000000, LATENCY=2, `resp_ready`=1. Expect `req_ready[1]` in cycle 0, `resp_valid`=4'b0010 in cycle 3, `resp_y`=0x40400000, `busy` low in cycle 4.
- **Round-robin:** all four `req_valid` held high with x1=0x3F800000, x2=0x40800000. Expect grant order 0,1,2,3,0, each `resp_y`=0x3E800000, and acceptances spaced exactly LATENCY+2 cycles apart.
- **Backpressure:** `resp_ready[2]`=0 for 10 cycles after `resp_valid[2]` rises. Expect `resp_y` stable, no `req_ready` while requester 0 is pending, and requester 0 accepted in the cycle after the response handshake.
- **Zero dividend:** x1=0x80000000, x2=0x40000000. Expect `resp_y`=0x80000000, with `resp_valid` at c+1 under `FDIV_ARB_ZERO_BYPASS_EN` and at c+LATENCY+1 without it.
- **Reset mid-CALC:** `rst` pulsed for 1 cycle at c+1. Expect no `resp_valid` ever for that op, all outputs 0 afterwards, pointer restored so requester 0 wins the next arbitration.
- **Random:** 10000 random operand pairs from random requesters with random `resp_ready`. A scoreboard checks each result against the `fdiv` model, that results return to the issuing requester, and that no request is starved for more than NREQ grants.
